// File: rtl/clk_meas_pkg.sv
// Shared types and constants for the clock period meter.
package clk_meas_pkg;

  // Default width of the interval counter and result.
  localparam int unsigned DEF_CNT_W = 32;

  // Number of flops in the synchronizer chain for sig_in.
  localparam int unsigned SYNC_STAGES = 2;

  // Measurement FSM states; the encoding is visible on the debug port.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_e;

endpackage

// File: rtl/clock_period_meter_sync_edge_det.sv
// Synchronizes an asynchronous level and flags both its rising and its falling
// transitions. Usable for any slow asynchronous strobe in the clock fabric.
module sync_edge_det
  import clk_meas_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic edge_o,
  output logic level_prev_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchronizer chain followed by a one-cycle history register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // An edge is any difference between the synchronized level and its history.
  assign edge_o       = sync_q[SYNC_STAGES-1] ^ prev_q;
  assign level_prev_o = prev_q;

endmodule

// File: rtl/clock_period_meter.sv
// Measures the interval between consecutive edges of a slow asynchronous
// square wave in inclk cycles and offers each interval on a valid/ready port.
// Also raises sticky flags for loss of signal (timeout) and dropped results
// (overrun).
//
// Result handshake: meas_valid rises when a result is loaded and stays high
// until a cycle with meas_valid & meas_ready, which is the single transfer
// cycle. meas_half/meas_level are held stable while meas_valid=1 and
// meas_ready=0. A new result may be loaded in the transfer cycle itself.
module clock_period_meter
  import clk_meas_pkg::*;
#(
  parameter int unsigned      CNT_W   = DEF_CNT_W,
  parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(100_000_000)
) (
  input  logic             inclk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             sig_in,
  output logic [CNT_W-1:0] meas_half,
  output logic             meas_level,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             timeout,
  output logic             overrun,
  output logic [1:0]       dbg_state
);

  logic             edge_det;
  logic             level_prev;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;

  logic [CNT_W-1:0] half_q,    half_d;
  logic             level_q,   level_d;
  logic             valid_q,   valid_d;
  logic             overrun_q, overrun_d;

  logic             capture;
  logic             transfer;

  sync_edge_det u_sync (
    .clk_i        (inclk),
    .rst_ni       (rst_n),
    .async_i      (sig_in),
    .edge_o       (edge_det),
    .level_prev_o (level_prev)
  );

  // A finished interval is produced by every edge seen while measuring.
  assign capture  = ena && (state_q == MEASURE) && edge_det;
  assign transfer = valid_q && meas_ready;

  // Measurement FSM with interval counter and loss-of-signal flag. An edge
  // coinciding with saturation still completes its interval.
  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else if (!ena) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q   <= '0;
          state_q <= ARM;
        end
        ARM: begin
          if (edge_det) begin
            cnt_q     <= CNT_W'(1);
            timeout_q <= 1'b0;
            state_q   <= MEASURE;
          end
        end
        MEASURE: begin
          if (edge_det) begin
            cnt_q     <= CNT_W'(1);
            timeout_q <= 1'b0;
          end else if (cnt_q == TIMEOUT) begin
            cnt_q     <= '0;
            timeout_q <= 1'b1;
            state_q   <= ARM;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Single-entry result slot: load when empty or draining, otherwise drop.
  always_comb begin
    half_d    = half_q;
    level_d   = level_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (transfer) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
    if (capture) begin
      if (!valid_q || transfer) begin
        half_d  = cnt_q;
        level_d = level_prev;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // Result slot and overrun registers.
  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      half_q    <= '0;
      level_q   <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      half_q    <= half_d;
      level_q   <= level_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign meas_half  = half_q;
  assign meas_level = level_q;
  assign meas_valid = valid_q;
  assign timeout    = timeout_q;
  assign overrun    = overrun_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter with TIMEOUT=50.
module tb_clock_period_meter;
  import clk_meas_pkg::*;

  localparam int CNT_W = 32;

  logic             inclk;
  logic             rst_n;
  logic             ena;
  logic             sig_in;
  logic [CNT_W-1:0] meas_half;
  logic             meas_level;
  logic             meas_valid;
  logic             meas_ready;
  logic             timeout;
  logic             overrun;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic mon_en = 1'b0;
  logic lv;

  // Expected results as {level, interval}, consumed on each transfer.
  logic [CNT_W:0] exp_q[$];

  clock_period_meter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (32'd50)
  ) dut (
    .inclk      (inclk),
    .rst_n      (rst_n),
    .ena        (ena),
    .sig_in     (sig_in),
    .meas_half  (meas_half),
    .meas_level (meas_level),
    .meas_valid (meas_valid),
    .meas_ready (meas_ready),
    .timeout    (timeout),
    .overrun    (overrun),
    .dbg_state  (dbg_state)
  );

  // Clock and watchdog.
  initial inclk = 1'b0;
  always #5 inclk = ~inclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver tasks: inputs change 1ns after the rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge inclk);
      #1;
    end
  endtask

  // Wait gap cycles, then toggle sig_in; exp_val!=0 queues the result this
  // edge should produce (level before the edge, interval exp_val).
  task automatic tog(input int gap, input int exp_val);
    tick(gap);
    if (exp_val != 0) exp_q.push_back({sig_in, CNT_W'(exp_val)});
    sig_in = ~sig_in;
  endtask

  // Scoreboard: a transfer happens on the next rising edge when valid&ready
  // are seen here on the falling edge.
  always @(negedge inclk) begin
    if (mon_en && meas_valid && meas_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_result", meas_valid, 1'b0);
      end else begin
        check("result", {meas_level, meas_half}, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0; ena = 1'b0; sig_in = 1'b0; meas_ready = 1'b0;
    tick(3);
    check("rst_half", meas_half, 0);
    check("rst_level", meas_level, 0);
    check("rst_valid", meas_valid, 0);
    check("rst_timeout", timeout, 0);
    check("rst_overrun", overrun, 0);
    check("rst_state", dbg_state, IDLE);
    rst_n = 1'b1;
    tick(2);

    // S1: divider maxcount=3, consumer always ready.
    mon_en = 1'b1; meas_ready = 1'b1; ena = 1'b1;
    tick(3);
    check("s1_armed", dbg_state, ARM);
    tog(1, 0);
    repeat (7) tog(4, 4);
    tick(8);
    check("s1_all_results", exp_q.size(), 0);
    check("s1_timeout", timeout, 0);
    check("s1_overrun", overrun, 0);
    ena = 1'b0; mon_en = 1'b0;
    tick(3);

    // S2: consumer stalls for 20 cycles.
    meas_ready = 1'b0; ena = 1'b1;
    tick(3);
    tog(1, 0);
    lv = sig_in;
    tog(4, 0);
    tog(4, 0);
    check("s2_first_valid", meas_valid, 1);
    check("s2_first_half", meas_half, 4);
    check("s2_first_level", meas_level, lv);
    tog(4, 0);
    check("s2_overrun_set", overrun, 1);
    check("s2_hold_half", meas_half, 4);
    tog(4, 0);
    tog(4, 0);
    check("s2_hold_half_end", meas_half, 4);
    check("s2_hold_level_end", meas_level, lv);
    check("s2_overrun_end", overrun, 1);
    lv = ~sig_in;
    meas_ready = 1'b1;
    tick(1);
    check("s2_drained_valid", meas_valid, 0);
    check("s2_overrun_clear", overrun, 0);
    tick(2);
    check("s2_next_valid", meas_valid, 1);
    check("s2_next_half", meas_half, 4);
    check("s2_next_level", meas_level, lv);
    tick(1);
    ena = 1'b0;
    tick(3);

    // S3: signal stops after two edges; timeout then recovery.
    mon_en = 1'b1; ena = 1'b1;
    tick(3);
    tog(1, 0);
    tog(4, 4);
    tick(52);
    check("s3_timeout_early", timeout, 0);
    tick(1);
    check("s3_timeout_set", timeout, 1);
    check("s3_state_arm", dbg_state, ARM);
    check("s3_no_result", meas_valid, 0);
    tog(3, 0);
    tick(3);
    check("s3_timeout_clear", timeout, 0);
    check("s3_rearm_no_result", meas_valid, 0);
    tog(3, 6);
    tick(8);
    check("s3_all_results", exp_q.size(), 0);
    ena = 1'b0; mon_en = 1'b0;
    tick(3);

    // S4: a capture lands in the transfer cycle.
    meas_ready = 1'b0; ena = 1'b1;
    tick(3);
    tog(1, 0);
    tog(4, 0);
    tog(5, 0);
    lv = ~sig_in;
    tick(2);
    check("s4_pending_half", meas_half, 4);
    meas_ready = 1'b1;
    tick(1);
    check("s4_valid_kept", meas_valid, 1);
    check("s4_new_half", meas_half, 5);
    check("s4_new_level", meas_level, lv);
    check("s4_no_overrun", overrun, 0);
    tick(1);
    check("s4_drained", meas_valid, 0);
    ena = 1'b0;
    tick(3);

    // S5: enable dropped mid-interval for 10 cycles.
    mon_en = 1'b1; ena = 1'b1;
    tick(3);
    tog(1, 0);
    tog(4, 4);
    tick(6);
    ena = 1'b0;
    tick(5);
    sig_in = ~sig_in;
    tick(5);
    check("s5_idle", dbg_state, IDLE);
    check("s5_no_partial", meas_valid, 0);
    ena = 1'b1;
    tick(3);
    tog(2, 0);
    tog(7, 7);
    tick(8);
    check("s5_all_results", exp_q.size(), 0);
    ena = 1'b0; mon_en = 1'b0;
    tick(3);

    // S6: asynchronous reset with a pending result and overrun.
    meas_ready = 1'b0; ena = 1'b1;
    tick(3);
    tog(1, 0);
    tog(4, 0);
    tog(4, 0);
    tick(4);
    check("s6_pre_valid", meas_valid, 1);
    check("s6_pre_overrun", overrun, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_rst_half", meas_half, 0);
    check("s6_rst_level", meas_level, 0);
    check("s6_rst_valid", meas_valid, 0);
    check("s6_rst_overrun", overrun, 0);
    check("s6_rst_timeout", timeout, 0);
    check("s6_rst_state", dbg_state, IDLE);
    tick(1);
    rst_n = 1'b1; ena = 1'b0;
    tick(4);
    mon_en = 1'b1; meas_ready = 1'b1; ena = 1'b1;
    tick(3);
    tog(1, 0);
    repeat (4) tog(4, 4);
    tick(8);
    check("s6_all_results", exp_q.size(), 0);
    check("s6_overrun", overrun, 0);
    check("s6_timeout", timeout, 0);
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/clock_period_meter.md
# clock_period_meter

Measures the half-period of a slow, asynchronous square wave (typically the output of a `clock_divider` instance, on-chip or looped back through a pin) in `inclk` cycles. Each measured interval between consecutive edges is offered on a valid/ready output port. The block also flags loss of the signal (timeout) and dropped results (overrun). It sits beside the dividers in the multi-core clocking fabric as their self-check and calibration receiver.

## Interface
- `CNT_W`, 32: width of the interval counter and result.
- `TIMEOUT`, 32'd100_000_000: `inclk` cycles without an edge before `timeout` asserts. Legal range is 2 .. 2^CNT_W-1.
- `inclk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ena`  in  1  measurement enable; when low, the block idles.
- `sig_in`  in  1  asynchronous signal under measurement.
- `meas_half`  out  CNT_W  measured interval in `inclk` cycles; reset 0.
- `meas_level`  out  1  level of `sig_in` during the measured interval; reset 0.
- `meas_valid`  out  1  result pending; reset 0.
- `meas_ready`  in  1  consumer accepts the result.
- `timeout`  out  1  sticky: no edge for `TIMEOUT` cycles; reset 0.
- `overrun`  out  1  sticky: a result was dropped; reset 0.

## Operation
- `sig_in` passes through a 2-FF synchronizer, then an edge register. An edge is `sync2 != prev`, and is detected on both rising and falling edges.
- The FSM has three states:
  - IDLE: counter held at 0. Leave for ARM when `ena`=1.
  - ARM: wait for the first edge, with no result produced. On an edge, load counter=1 and go to MEASURE.
  - MEASURE: the counter increments every cycle. On an edge, capture the counter into the result slot, reload counter=1, and stay in MEASURE.
- `ena`=0 in any state forces IDLE next cycle and clears the counter and `timeout`. A pending result stays valid and drainable.
- Result value equals t1 - t0, where t0 and t1 are the cycles of consecutive edge detections.
  - Example: a divider with maxcount=N yields N+1 in every interval.
- `meas_level` is the value of `prev` at capture, i.e. the level before the edge.
- Counter saturation: when the counter reaches `TIMEOUT` in MEASURE, set `timeout`, go to ARM, and discard the partial interval. The counter never wraps.
- `timeout` clears on the next edge detection, or when `ena`=0.
- Result handshake:
  - `meas_half`/`meas_level` stay stable while `meas_valid`=1 and `meas_ready`=0.
  - A transfer occurs on a cycle with `meas_valid`&`meas_ready`.
- Capture rules:
  - Slot empty: load the slot and set valid.
  - Slot full, with transfer in the same cycle: load the new value and keep valid at 1. No overrun.
  - Slot full, no transfer: drop the new value, keep the old one, and set `overrun`.
- `overrun` clears on the next completed transfer; a fresh drop in that same cycle wins.
- Reset mid-operation: all state, outputs and synchronizer flops go to 0 immediately. The first edge after reset only arms.

## Timing
- `sig_in` transition sampled at `inclk` edge k: sync1 at k, sync2 at k+1, edge visible in the cycle after k+1, captured at k+2. `meas_valid` is high after edge k+2 (3-cycle latency).
- Minimum measurable interval is 1. Edge detections on consecutive cycles give result 1; this cannot occur with a divider input and is covered only for completeness.
- Throughput: one result per edge, provided the consumer holds `meas_ready`=1.
- `timeout` asserts the cycle after the counter equals `TIMEOUT`. The FSM is in ARM from the same edge.

## Structure
- Package `clk_meas_pkg`:
  - state enum `{IDLE, ARM, MEASURE}`
  - default `CNT_W`
  - localparam for synchronizer depth (2)
- Sub-module `sync_edge_det`:
  - 2-FF synchronizer plus previous-value register, async active-low reset.
  - Outputs `edge` and `level_prev`.
  - Reusable for other asynchronous strobes in the fabric.
- Top level contains the FSM, counter, single-entry result slot, and sticky flags.

## Test plan
- `sig_in` driven by `clock_divider` with maxcount=3, `ena`=1, `meas_ready`=1 → after arming, every result = 4 and `meas_level` alternates 1,0,1,0. No flags.
- Same stimulus, `meas_ready`=0 for 20 cycles → the first result is held stable and `overrun`=1. The first transfer after `ready` rises returns the held value, then `overrun`=0.
- `TIMEOUT`=50, `sig_in` frozen after two edges → `timeout`=1 exactly 51 cycles after the last edge detection, with no new result. The next edge clears `timeout` and arms only; the second following edge gives a correct result.
- Capture coinciding with a transfer cycle (`valid`=1, `ready`=1, edge) → new value loaded, `valid` stays 1, `overrun` stays 0.
- `ena` dropped mid-interval, then raised after 10 cycles → no partial result. The first edge after re-enable arms; the following interval is exact.
- `rst_n` asserted asynchronously mid-MEASURE with a pending result → all outputs 0 before the next `inclk` edge. After release, behaviour matches the first scenario.
